// File: rtl/lab61soc_pio_arbiter.sv
// Round-robin arbiter that lets two Avalon-MM masters share one zero-wait-state PIO slave.
// Each grant carries exactly one transfer. The IDLE cycle between grants re-evaluates both requests.
module lab61soc_pio_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_chipselect,
    input  logic              m0_write_n,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_chipselect,
    input  logic              m1_write_n,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_chipselect,
    output logic              s_write_n,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   pick_m0;
    logic   pick_m1;

    // m0 wins unless m1 is also requesting and m0 was the last master served.
    assign pick_m0 = m0_chipselect && (!m1_chipselect || last_grant);
    assign pick_m1 = m1_chipselect && !pick_m0;

    // NOTE: non-blocking assignments make every register update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_m0) begin
                        state      <= GNT0;
                        last_grant <= 1'b0;
                    end else if (pick_m1) begin
                        state      <= GNT1;
                        last_grant <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state and master inputs only. s_readdata reaches readdata alone.
    // NOTE: every output gets a default before the case, so no latch is inferred.
    always_comb begin
        s_address      = '0;
        s_chipselect   = 1'b0;
        s_write_n      = 1'b1;
        s_writedata    = '0;
        m0_readdata    = '0;
        m1_readdata    = '0;
        m0_waitrequest = m0_chipselect;
        m1_waitrequest = m1_chipselect;
        case (state)
            GNT0: begin
                s_address      = m0_address;
                s_chipselect   = m0_chipselect;
                s_write_n      = m0_write_n;
                s_writedata    = m0_writedata;
                m0_waitrequest = 1'b0;
                m0_readdata    = s_readdata;
            end
            GNT1: begin
                s_address      = m1_address;
                s_chipselect   = m1_chipselect;
                s_write_n      = m1_write_n;
                s_writedata    = m1_writedata;
                m1_waitrequest = 1'b0;
                m1_readdata    = s_readdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lab61soc_pio_arbiter.sv
// Bench for lab61soc_pio_arbiter. A four-word PIO slave model sits behind the DUT.
// A grant-level reference model predicts every output in every cycle.
module tb_lab61soc_pio_arbiter;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] s_address;
        logic              s_chipselect;
        logic              s_write_n;
        logic [DATA_W-1:0] s_writedata;
        logic [DATA_W-1:0] m0_readdata;
        logic [DATA_W-1:0] m1_readdata;
        logic              m0_waitrequest;
        logic              m1_waitrequest;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [ADDR_W-1:0] m0_address = '0, m1_address = '0, s_address;
    logic m0_chipselect = 1'b0, m1_chipselect = 1'b0, s_chipselect;
    logic m0_write_n = 1'b1, m1_write_n = 1'b1, s_write_n;
    logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0, s_writedata;
    logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
    logic m0_waitrequest, m1_waitrequest;

    logic [DATA_W-1:0] slave_mem [4] = '{default: '0};
    logic [DATA_W-1:0] ref_mem   [4] = '{default: '0};
    logic [DATA_W-1:0] wr_log [$];

    int mdl_gnt  = -1;  // master owning the current cycle, -1 for none
    int mdl_last = 1;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign s_readdata = slave_mem[s_address];

    lab61soc_pio_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_chipselect(m0_chipselect), .m0_write_n(m0_write_n),
        .m0_writedata(m0_writedata), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_chipselect(m1_chipselect), .m1_write_n(m1_write_n),
        .m1_writedata(m1_writedata), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
        .s_writedata(s_writedata), .s_readdata(s_readdata)
    );

    // Round robin: a lone requester wins. Under contention, the master not served last wins.
    function automatic int rr_pick(logic r0, logic r1, int last);
        if (r0 && r1) return 1 - last;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic obs_t expected();
        obs_t e;
        e = '0;
        e.s_write_n      = 1'b1;
        e.m0_waitrequest = m0_chipselect;
        e.m1_waitrequest = m1_chipselect;
        if (mdl_gnt == 0) begin
            e.s_address      = m0_address;
            e.s_chipselect   = m0_chipselect;
            e.s_write_n      = m0_write_n;
            e.s_writedata    = m0_writedata;
            e.m0_waitrequest = 1'b0;
            e.m0_readdata    = ref_mem[m0_address];
        end else if (mdl_gnt == 1) begin
            e.s_address      = m1_address;
            e.s_chipselect   = m1_chipselect;
            e.s_write_n      = m1_write_n;
            e.s_writedata    = m1_writedata;
            e.m1_waitrequest = 1'b0;
            e.m1_readdata    = ref_mem[m1_address];
        end
        return e;
    endfunction

    // One clock cycle: sample outputs mid-cycle, then run the slave write and advance the model at the edge.
    task automatic step(output obs_t o, output obs_t e);
        if (!reset_n) begin
            mdl_gnt  = -1;
            mdl_last = 1;
        end
        #2;
        o.s_address      = s_address;
        o.s_chipselect   = s_chipselect;
        o.s_write_n      = s_write_n;
        o.s_writedata    = s_writedata;
        o.m0_readdata    = m0_readdata;
        o.m1_readdata    = m1_readdata;
        o.m0_waitrequest = m0_waitrequest;
        o.m1_waitrequest = m1_waitrequest;
        e = expected();
        if (o.s_chipselect && !o.s_write_n) begin
            slave_mem[o.s_address] = o.s_writedata;
            wr_log.push_back(o.s_writedata);
        end
        if (mdl_gnt == 0 && m0_chipselect && !m0_write_n) ref_mem[m0_address] = m0_writedata;
        if (mdl_gnt == 1 && m1_chipselect && !m1_write_n) ref_mem[m1_address] = m1_writedata;
        @(posedge clk);
        if (!reset_n) begin
            mdl_gnt  = -1;
            mdl_last = 1;
        end else if (mdl_gnt != -1) begin
            mdl_gnt = -1;
        end else begin
            mdl_gnt = rr_pick(m0_chipselect, m1_chipselect, mdl_last);
            if (mdl_gnt != -1) mdl_last = mdl_gnt;
        end
        #1;
    endtask

    task automatic idle_inputs();
        m0_chipselect = 1'b0;
        m1_chipselect = 1'b0;
        m0_write_n    = 1'b1;
        m1_write_n    = 1'b1;
    endtask

    task automatic test_reset();
        obs_t o, e;
        for (int i = 0; i < 4; i++) begin
            m0_chipselect = 1'($urandom_range(1));
            m1_chipselect = 1'($urandom_range(1));
            m0_address    = 2'($urandom_range(3));
            m0_writedata  = $urandom;
            step(o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset cyc%0d: got %h expected %h", i, o, e);
            end
        end
        idle_inputs();
        reset_n = 1'b1;
        step(o, e);
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL reset_release: got %h expected %h", o, e);
        end
    endtask

    task automatic test_m0_write();
        obs_t o, e;
        m0_chipselect = 1'b1;
        m0_write_n    = 1'b0;
        m0_address    = 2'd0;
        m0_writedata  = 32'h1;
        step(o, e);
        n_cmp++;
        if (o !== e || o.m0_waitrequest !== 1'b1) begin
            n_bad++;
            $display("FAIL m0_write_req: got %h expected %h", o, e);
        end
        step(o, e);
        n_cmp++;
        if (o !== e || {o.s_chipselect, o.s_write_n, o.s_writedata, o.m0_waitrequest} !== {1'b1, 1'b0, 32'h1, 1'b0}) begin
            n_bad++;
            $display("FAIL m0_write_gnt: got %h expected %h", o, e);
        end
        m0_write_n = 1'b1;
        m0_writedata = '0;
        for (int i = 0; i < 3; i++) begin
            m0_chipselect = (i != 0);
            step(o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL m0_readback cyc%0d: got %h expected %h", i, o, e);
            end
        end
        n_cmp++;
        if (o.m0_readdata !== 32'h1 || o.m0_waitrequest !== 1'b0) begin
            n_bad++;
            $display("FAIL m0_readback_value: got rd %h wr %b, need rd 00000001 wr 0", o.m0_readdata, o.m0_waitrequest);
        end
        idle_inputs();
        step(o, e);
    endtask

    task automatic test_m1_read();
        obs_t o, e;
        m1_chipselect = 1'b1;
        m1_write_n    = 1'b1;
        m1_address    = 2'd0;
        step(o, e);
        n_cmp++;
        if (o !== e || o.m1_waitrequest !== 1'b1) begin
            n_bad++;
            $display("FAIL m1_read_req: got %h expected %h", o, e);
        end
        step(o, e);
        n_cmp++;
        if (o !== e || {o.m1_readdata, o.m1_waitrequest, o.m0_readdata} !== {32'h1, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL m1_read_gnt: got %h expected %h", o, e);
        end
        idle_inputs();
        step(o, e);
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        logic [DATA_W-1:0] vals [3] = '{32'hA, 32'hB, 32'hC};
        int gcyc [$];
        int idx = 0;
        wr_log.delete();
        m0_address = 2'd2;
        m0_write_n = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            m0_chipselect = (idx < 3);
            m0_writedata  = (idx < 3) ? vals[idx] : '0;
            step(o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL b2b cyc%0d: got %h expected %h", cyc, o, e);
            end
            if (m0_chipselect && !o.m0_waitrequest) begin
                gcyc.push_back(cyc);
                idx++;
            end
        end
        n_cmp++;
        if (gcyc.size() != 3 || gcyc[0] != 1 || gcyc[1] != 3 || gcyc[2] != 5) begin
            n_bad++;
            $display("FAIL b2b_grant_cycles: got %0d grants first at %0d, need 3 grants on 1,3,5",
                     gcyc.size(), (gcyc.size() > 0) ? gcyc[0] : -1);
        end
        n_cmp++;
        if (wr_log.size() != 3 || wr_log[0] !== 32'hA || wr_log[1] !== 32'hB || wr_log[2] !== 32'hC) begin
            n_bad++;
            $display("FAIL b2b_slave_writes: got %0d writes, need A,B,C in order", wr_log.size());
        end
        idle_inputs();
    endtask

    task automatic test_contention();
        obs_t o, e;
        int g0 = 0, g1 = 0, first = -1;
        reset_n = 1'b0;
        step(o, e);
        reset_n = 1'b1;
        m0_chipselect = 1'b1;
        m1_chipselect = 1'b1;
        m0_write_n = 1'b1;
        m1_write_n = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            step(o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL contention cyc%0d: got %h expected %h", cyc, o, e);
            end
            if (!o.m0_waitrequest) begin
                g0++;
                if (first < 0) first = 0;
            end
            if (!o.m1_waitrequest) begin
                g1++;
                if (first < 0) first = 1;
            end
        end
        n_cmp++;
        if (g0 != 2 || g1 != 2 || first != 0) begin
            n_bad++;
            $display("FAIL contention_share: got m0 %0d m1 %0d first m%0d, need 2/2 first m0", g0, g1, first);
        end
        idle_inputs();
        step(o, e);
    endtask

    task automatic test_reset_during_gnt1();
        obs_t o, e;
        m1_chipselect = 1'b1;
        m1_write_n    = 1'b0;
        m1_address    = 2'd3;
        m1_writedata  = 32'hDEAD;
        step(o, e);
        wr_log.delete();
        reset_n = 1'b0;
        step(o, e);
        n_cmp++;
        if (o !== e || o.s_chipselect !== 1'b0 || o.m1_waitrequest !== 1'b1 || wr_log.size() != 0) begin
            n_bad++;
            $display("FAIL reset_in_gnt1: got %h expected %h writes %0d", o, e, wr_log.size());
        end
        reset_n = 1'b1;
        m0_chipselect = 1'b1;
        m0_write_n    = 1'b1;
        m1_write_n    = 1'b1;
        step(o, e);
        step(o, e);
        n_cmp++;
        if (o !== e || {o.m0_waitrequest, o.m1_waitrequest} !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_then_m0_first: got %h expected %h", o, e);
        end
        idle_inputs();
        step(o, e);
    endtask

    task automatic test_cs_drop();
        obs_t o, e;
        m0_chipselect = 1'b1;
        m0_write_n    = 1'b0;
        m0_address    = 2'd1;
        m0_writedata  = 32'hBAD0;
        step(o, e);
        wr_log.delete();
        m0_chipselect = 1'b0;
        m1_chipselect = 1'b1;
        m1_write_n    = 1'b0;
        m1_address    = 2'd1;
        m1_writedata  = 32'h55;
        step(o, e);
        n_cmp++;
        if (o !== e || o.s_chipselect !== 1'b0 || o.m1_waitrequest !== 1'b1) begin
            n_bad++;
            $display("FAIL cs_drop_gnt0: got %h expected %h", o, e);
        end
        step(o, e);
        step(o, e);
        n_cmp++;
        if (o !== e || o.m1_waitrequest !== 1'b0) begin
            n_bad++;
            $display("FAIL cs_drop_m1_gnt: got %h expected %h", o, e);
        end
        idle_inputs();
        step(o, e);
        n_cmp++;
        if (wr_log.size() != 1 || wr_log[0] !== 32'h55) begin
            n_bad++;
            $display("FAIL cs_drop_writes: got %0d writes, need exactly one of 00000055", wr_log.size());
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        int bad0 = n_bad;
        for (int i = 0; i < 400; i++) begin
            step(o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                if (n_bad - bad0 < 10) $display("FAIL random cyc%0d: got %h expected %h", i, o, e);
            end
            if (m0_chipselect && (!o.m0_waitrequest || $urandom_range(19) == 0)) m0_chipselect = 1'b0;
            else if (!m0_chipselect && $urandom_range(2) == 0) begin
                m0_chipselect = 1'b1;
                m0_address    = 2'($urandom_range(3));
                m0_write_n    = 1'($urandom_range(1));
                m0_writedata  = $urandom;
            end
            if (m1_chipselect && (!o.m1_waitrequest || $urandom_range(19) == 0)) m1_chipselect = 1'b0;
            else if (!m1_chipselect && $urandom_range(2) == 0) begin
                m1_chipselect = 1'b1;
                m1_address    = 2'($urandom_range(3));
                m1_write_n    = 1'($urandom_range(1));
                m1_writedata  = $urandom;
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_m0_write();
        test_m1_read();
        test_back_to_back();
        test_contention();
        test_reset_during_gnt1();
        test_cs_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
